// File: rtl/ps2_kempston_mouse_x_if.sv
// Z80 I/O bus view of the Kempston mouse ports.
// master drives the port address, slave answers with decode hit and data.
interface ps2_kempston_mouse_x_if;
  logic [2:0] addr;
  logic       sel;
  logic [7:0] dout;

  modport master (
    output addr,
    input  sel,
    input  dout
  );

  modport slave (
    input  addr,
    output sel,
    output dout
  );
endinterface

// File: rtl/ps2_kempston_mouse_x.sv
// PS/2 mouse receiver feeding Kempston X/Y/button ports.
// Optional IntelliMouse wheel support: define MOUSE_WHEEL_EN.
module ps2_kempston_mouse_x #(
  parameter int CNT_W      = 8,
  parameter int DIV_SHIFT  = 0,
  parameter int IDLE_TICKS = 3500000
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ce_7mp,
  input  logic             ps2_mouse_clk,
  input  logic             ps2_mouse_data,
  input  logic             wrap_mode,
  input  logic             swap_lr,
  ps2_kempston_mouse_x_if.slave bus,
  output logic [CNT_W-1:0] x_pos,
  output logic [CNT_W-1:0] y_pos,
  output logic             pkt_strobe
);

`ifdef MOUSE_WHEEL_EN
  localparam logic [1:0] LAST = 2'd3;
`else
  localparam logic [1:0] LAST = 2'd2;
`endif
  localparam int IW = $clog2(IDLE_TICKS + 1);
  localparam int SW = CNT_W + 2;
  localparam logic [CNT_W-1:0] X_RST = {1'b1, {(CNT_W-1){1'b0}}};

  typedef enum logic {
    FRAME_IDLE,
    FRAME_BITS
  } frame_t;

  frame_t state, state_n;

  logic clk_s1, clk_s2, clk_d;
  logic dat_s1, dat_s2;
  logic fall;
  logic [IW-1:0] idle_cnt;
  logic timeout;
  logic [3:0] bit_cnt;
  logic [8:0] sr;
  logic frame_done, frame_ok;
  logic [1:0] idx;
  logic commit_pend;
  logic [2:0] btn_p;
  logic sx, sy;
  logic [7:0] b1, b2;
  logic left, right, middle;
  logic btn_a, btn_b;
  logic [3:0] wheel_nib;
  logic hit_x, hit_y, hit_b;

  // Add a (shifted) 9-bit packet delta to a position, wrapping or clamping.
  function automatic logic [CNT_W-1:0] acc(
    input logic [CNT_W-1:0] pos,
    input logic [8:0]       d,
    input logic             wrap
  );
    logic signed [8:0]    ds;
    logic signed [SW-1:0] sum;
    ds  = $signed(d) >>> DIV_SHIFT;
    sum = $signed({2'b00, pos}) + $signed({{(SW-9){ds[8]}}, ds});
    if (wrap)
      return sum[CNT_W-1:0];
    if (sum[SW-1])
      return '0;
    if (sum[SW-2:CNT_W] != '0)
      return '1;
    return sum[CNT_W-1:0];
  endfunction

  assign fall    = clk_d & ~clk_s2;
  assign timeout = (idle_cnt == IW'(IDLE_TICKS)) & ~fall;

  // Two-flop synchronisers plus a delayed clock copy for edge detection.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_d  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_mouse_clk;
      clk_s2 <= clk_s1;
      clk_d  <= clk_s2;
      dat_s1 <= ps2_mouse_data;
      dat_s2 <= dat_s1;
    end
  end

  // Idle timer: counts enabled ticks of PS/2 clock high, any edge clears it.
  always_ff @(posedge clk_sys) begin
    if (reset)
      idle_cnt <= '0;
    else if (fall || timeout)
      idle_cnt <= '0;
    else if (clk_s2 && ce_7mp)
      idle_cnt <= idle_cnt + 1'b1;
  end

  // Frame FSM state register.
  always_ff @(posedge clk_sys) begin
    if (reset)
      state <= FRAME_IDLE;
    else
      state <= state_n;
  end

  // Frame FSM next state; flags a finished frame and its validity.
  always_comb begin
    state_n    = state;
    frame_done = 1'b0;
    frame_ok   = 1'b0;
    unique case (state)
      FRAME_IDLE: begin
        if (fall && !dat_s2)
          state_n = FRAME_BITS;
      end
      FRAME_BITS: begin
        if (fall && bit_cnt == 4'd9) begin
          frame_done = 1'b1;
          frame_ok   = (^sr) & dat_s2;
          state_n    = FRAME_IDLE;
        end else if (timeout) begin
          state_n = FRAME_IDLE;
        end
      end
      default: state_n = FRAME_IDLE;
    endcase
  end

  // Bit shifter: LSB-first data then parity; the stop bit is only inspected.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bit_cnt <= '0;
      sr      <= '0;
    end else if (fall) begin
      if (state == FRAME_IDLE) begin
        bit_cnt <= '0;
      end else begin
        sr      <= {dat_s2, sr[8:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

  // Packet assembly: header check, byte storage, commit request.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      idx         <= '0;
      commit_pend <= 1'b0;
      btn_p       <= '0;
      sx          <= 1'b0;
      sy          <= 1'b0;
      b1          <= '0;
      b2          <= '0;
    end else begin
      commit_pend <= 1'b0;
      if (frame_done) begin
        if (!frame_ok) begin
          idx <= '0;
        end else if (idx == 2'd0 && !sr[3]) begin
          idx <= '0;
        end else begin
          if (idx == 2'd0) begin
            btn_p <= sr[2:0];
            sx    <= sr[4];
            sy    <= sr[5];
          end
          if (idx == 2'd1)
            b1 <= sr[7:0];
          if (idx == 2'd2)
            b2 <= sr[7:0];
          if (idx == LAST) begin
            idx         <= '0;
            commit_pend <= 1'b1;
          end else begin
            idx <= idx + 2'd1;
          end
        end
      end else if (timeout) begin
        idx <= '0;
      end
    end
  end

`ifdef MOUSE_WHEEL_EN
  logic [3:0] b3;
  logic [3:0] wheel;

  // Wheel byte capture and wrapping wheel accumulator.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      b3    <= '0;
      wheel <= '0;
    end else begin
      if (frame_done && frame_ok && idx == 2'd3)
        b3 <= sr[3:0];
      if (commit_pend)
        wheel <= wheel + b3;
    end
  end

  assign wheel_nib = wheel;
`else
  assign wheel_nib = 4'hF;
`endif

  // Commit: update positions and buttons, pulse the strobe.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      x_pos      <= X_RST;
      y_pos      <= '0;
      left       <= 1'b0;
      right      <= 1'b0;
      middle     <= 1'b0;
      pkt_strobe <= 1'b0;
    end else begin
      pkt_strobe <= commit_pend;
      if (commit_pend) begin
        x_pos  <= acc(x_pos, {sx, b1}, wrap_mode);
        y_pos  <= acc(y_pos, {sy, b2}, wrap_mode);
        left   <= btn_p[0];
        right  <= btn_p[1];
        middle <= btn_p[2];
      end
    end
  end

  assign btn_a = swap_lr ? right : left;
  assign btn_b = swap_lr ? left : right;
  assign hit_x = (bus.addr == 3'b011);
  assign hit_y = (bus.addr == 3'b111);
  assign hit_b = (bus.addr[1:0] == 2'b10);

  // Kempston port decode.
  always_comb begin
    bus.sel  = 1'b1;
    bus.dout = 8'hFF;
    unique case (1'b1)
      hit_x:   bus.dout = x_pos[7:0];
      hit_y:   bus.dout = y_pos[7:0];
      hit_b:   bus.dout = {wheel_nib, 1'b1, ~middle, ~btn_a, ~btn_b};
      default: bus.sel  = 1'b0;
    endcase
  end

endmodule
